// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: turns divider toggle pulses into codec pins and
// serialises held stereo pairs MSB-first with the one-bit I2S delay.
module i2s_tx_sequencer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mclk_pulse,
    input  logic              lrck_pulse,
    input  logic              sclk_pulse,
    input  logic [DATA_W-1:0] left_data,
    input  logic [DATA_W-1:0] right_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              codec_mclk,
    output logic              codec_lrck,
    output logic              codec_sclk,
    output logic              codec_sdata,
    output logic              underflow,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              hold_full;
    logic [DATA_W-1:0] hold_left;
    logic [DATA_W-1:0] hold_right;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] right_hold;
    logic [CW-1:0]     bitcnt;
    logic              lrck_pend;

    logic active;
    logic fall;
    logic bnd;
    logic to_left;
    logic load;
    logic capture;

    assign active  = (state != IDLE) && enable;
    assign fall    = active && sclk_pulse && codec_sclk;
    assign bnd     = fall && (lrck_pend || lrck_pulse);
    assign to_left = bnd && codec_lrck;
    assign load    = to_left && hold_full;
    assign capture = sample_valid && !hold_full;

    assign sample_ready = !hold_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (enable) state_next = ARM;
            ARM: begin
                if (!enable) state_next = IDLE;
                else if (bnd) state_next = RUN;
            end
            RUN: if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // Capture and a left-boundary load are exclusive: capture needs an empty register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full  <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
        end else begin
            if (capture) begin
                hold_left  <= left_data;
                hold_right <= right_data;
            end
            if (capture) hold_full <= 1'b1;
            else if (load) hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            codec_mclk  <= 1'b0;
            codec_lrck  <= 1'b0;
            codec_sclk  <= 1'b0;
            codec_sdata <= 1'b0;
            underflow   <= 1'b0;
            shreg       <= '0;
            right_hold  <= '0;
            bitcnt      <= '0;
            lrck_pend   <= 1'b0;
        end else begin
            underflow <= to_left && !hold_full;
            if (state == IDLE) begin
                codec_mclk  <= 1'b0;
                codec_lrck  <= enable;
                codec_sclk  <= 1'b0;
                codec_sdata <= 1'b0;
                lrck_pend   <= 1'b0;
            end else if (!enable) begin
                codec_mclk  <= 1'b0;
                codec_lrck  <= 1'b0;
                codec_sclk  <= 1'b0;
                codec_sdata <= 1'b0;
                lrck_pend   <= 1'b0;
            end else begin
                if (mclk_pulse) codec_mclk <= !codec_mclk;
                if (sclk_pulse) codec_sclk <= !codec_sclk;
                if (bnd) begin
                    codec_lrck  <= !codec_lrck;
                    lrck_pend   <= 1'b0;
                    codec_sdata <= 1'b0;
                    bitcnt      <= '0;
                    if (to_left) begin
                        shreg      <= hold_full ? hold_left : '0;
                        right_hold <= hold_full ? hold_right : '0;
                    end else begin
                        shreg <= right_hold;
                    end
                end else begin
                    if (lrck_pulse) lrck_pend <= 1'b1;
                    if (fall) begin
                        if (state == RUN && bitcnt < CW'(DATA_W)) begin
                            codec_sdata <= shreg[DATA_W-1];
                            shreg       <= shreg << 1;
                            bitcnt      <= bitcnt + CW'(1);
                        end else begin
                            codec_sdata <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Directed bench for i2s_tx_sequencer: 16-bit and 24-bit instances sharing
// one pulse stream, slots collected bit-by-bit at SCLK falling events.
module tb_i2s_tx_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic mclk_pulse;
    logic lrck_pulse;
    logic sclk_pulse;

    logic        en16;
    logic        valid16;
    logic [15:0] left16;
    logic [15:0] right16;
    logic        ready16;
    logic        mclk16;
    logic        lrck16;
    logic        sclk16;
    logic        sdata16;
    logic        uf16;
    logic        busy16;

    logic        en24;
    logic        valid24;
    logic [23:0] left24;
    logic [23:0] right24;
    logic        ready24;
    logic        mclk24;
    logic        lrck24;
    logic        sclk24;
    logic        sdata24;
    logic        uf24;
    logic        busy24;

    i2s_tx_sequencer #(.DATA_W(16)) dut16 (
        .clk(clk), .reset(reset), .enable(en16),
        .mclk_pulse(mclk_pulse), .lrck_pulse(lrck_pulse),
        .sclk_pulse(sclk_pulse),
        .left_data(left16), .right_data(right16),
        .sample_valid(valid16), .sample_ready(ready16),
        .codec_mclk(mclk16), .codec_lrck(lrck16),
        .codec_sclk(sclk16), .codec_sdata(sdata16),
        .underflow(uf16), .busy(busy16)
    );

    i2s_tx_sequencer #(.DATA_W(24)) dut24 (
        .clk(clk), .reset(reset), .enable(en24),
        .mclk_pulse(mclk_pulse), .lrck_pulse(lrck_pulse),
        .sclk_pulse(sclk_pulse),
        .left_data(left24), .right_data(right24),
        .sample_valid(valid24), .sample_ready(ready24),
        .codec_mclk(mclk24), .codec_lrck(lrck24),
        .codec_sclk(sclk24), .codec_sdata(sdata24),
        .underflow(uf24), .busy(busy24)
    );

    int errors = 0;
    int checks = 0;
    int cnt = 0;
    bit auto_lr = 1'b1;
    int lr_a = -1;
    int lr_b = -1;
    bit fell = 1'b0;
    bit sel = 1'b0;
    logic [31:0] rx;
    int uf;
    int f_at;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Default divider: sclk toggle every 8 clk, falls at cnt%16==15.
    task automatic step();
        mclk_pulse = cnt[0];
        sclk_pulse = (cnt % 8 == 7);
        lrck_pulse = auto_lr ? (cnt % 512 == 15)
                             : (cnt == lr_a || cnt == lr_b);
        fell = (cnt % 16 == 15);
        @(posedge clk);
        #1;
        cnt++;
    endtask

    task automatic slot(input int n, output logic [31:0] bits,
                        output int ufs);
        int f;
        f = 0;
        bits = '0;
        ufs = 0;
        for (int i = 0; i < 16 * n + 16 && f < n; i++) begin
            step();
            if ((sel ? uf24 : uf16) === 1'b1) ufs++;
            if (fell) begin
                bits = {bits[30:0], (sel ? sdata24 : sdata16)};
                f++;
            end
        end
    endtask

    task automatic idle_edge();
        mclk_pulse = 1'b0;
        lrck_pulse = 1'b0;
        sclk_pulse = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        mclk_pulse = 1'b0;
        lrck_pulse = 1'b0;
        sclk_pulse = 1'b0;
        en16 = 1'b0; valid16 = 1'b0; left16 = '0; right16 = '0;
        en24 = 1'b0; valid24 = 1'b0; left24 = '0; right24 = '0;
        @(posedge clk);
        #1;
        chk("rst_pins", {mclk16, lrck16, sclk16, sdata16}, 0);
        chk("rst_ready", ready16, 1);
        chk("rst_busy", busy16, 0);
        chk("rst_uf", uf16, 0);
        reset = 1'b0;
        idle_edge();

        valid16 = 1'b1; left16 = 16'hA5C3; right16 = 16'h1234;
        idle_edge();
        valid16 = 1'b0;
        chk("hold_full", ready16, 0);

        en16 = 1'b1;
        idle_edge();
        cnt = 0;
        chk("arm_lrck", lrck16, 1);
        chk("arm_busy", busy16, 0);
        repeat (15) step();
        chk("pre_bnd_busy", busy16, 0);
        chk("pre_bnd_sclk", sclk16, 1);
        step();
        chk("bnd_busy", busy16, 1);
        chk("bnd_lrck", lrck16, 0);
        chk("bnd_sdata", sdata16, 0);
        chk("bnd_uf", uf16, 0);
        chk("bnd_ready", ready16, 1);

        slot(32, rx, uf);
        chk("left_a5c3", rx, 32'hA5C30000);
        chk("left_uf", uf, 0);
        chk("right_lrck", lrck16, 1);
        slot(32, rx, uf);
        chk("right_1234", rx, 32'h12340000);
        chk("uf_pulse", uf, 1);
        chk("uf_lrck", lrck16, 0);
        chk("uf_ready", ready16, 1);
        slot(32, rx, uf);
        chk("uf_left_zero", rx, 0);
        chk("uf_one_clk", uf, 0);

        valid16 = 1'b1; left16 = 16'h3333; right16 = 16'h4444;
        step();
        left16 = 16'h1111; right16 = 16'h2222;
        chk("hold_3333", ready16, 0);
        slot(32, rx, uf);
        chk("uf_right_zero", rx, 0);
        chk("load_no_uf", uf, 0);
        chk("load_ready", ready16, 1);
        step();
        chk("cap_next", ready16, 0);
        valid16 = 1'b0;
        slot(32, rx, uf);
        chk("left_3333", rx, 32'h33330000);
        slot(32, rx, uf);
        chk("right_4444", rx, 32'h44440000);
        chk("cap_no_uf", uf, 0);
        slot(32, rx, uf);
        chk("left_1111", rx, 32'h11110000);
        slot(32, rx, uf);
        chk("right_2222", rx, 32'h22220000);
        chk("uf_again", uf, 1);

        auto_lr = 1'b0;
        f_at = cnt + 63;
        lr_a = f_at - 3;
        lr_b = f_at - 1;
        while (cnt < f_at) step();
        chk("lr_pending", lrck16, 0);
        step();
        chk("lr_toggle", lrck16, 1);
        repeat (16) step();
        chk("lr_once", lrck16, 1);

        valid16 = 1'b1; left16 = 16'h5555; right16 = 16'h6666;
        step();
        valid16 = 1'b0;
        chk("pre_rst_ready", ready16, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pins", {mclk16, lrck16, sclk16, sdata16}, 0);
        chk("arst_ready", ready16, 1);
        chk("arst_busy", busy16, 0);
        en16 = 1'b0;
        #1;
        reset = 1'b0;
        idle_edge();

        sel = 1'b1;
        valid24 = 1'b1; left24 = 24'hABCDEF; right24 = 24'h123456;
        idle_edge();
        valid24 = 1'b0;
        en24 = 1'b1;
        idle_edge();
        cnt = 0;
        lr_a = 15;
        lr_b = 335;
        chk("w24_arm_lrck", lrck24, 1);
        repeat (15) step();
        chk("w24_mclk", mclk24, 1);
        chk("w24_sclk", sclk24, 1);
        chk("w24_pre_busy", busy24, 0);
        step();
        chk("w24_busy", busy24, 1);
        chk("w24_lrck", lrck24, 0);
        chk("w24_uf", uf24, 0);
        slot(20, rx, uf);
        chk("w24_short", rx, 32'h000ABCDE);
        chk("w24_short_uf", uf, 0);
        chk("w24_right_lrck", lrck24, 1);
        slot(32, rx, uf);
        chk("w24_right", rx, 32'h12345600);
        chk("w24_right_uf", uf, 0);

        repeat (5) step();
        en24 = 1'b0;
        step();
        chk("dis_pins", {mclk24, lrck24, sclk24, sdata24}, 0);
        chk("dis_busy", busy24, 0);
        chk("dis_ready", ready24, 1);
        repeat (20) step();
        chk("dis_hold_pins", {mclk24, lrck24, sclk24, sdata24}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
